// File: rtl/iir_channel_scheduler.sv
// Round-robin scheduler sharing one IIR step core across several channels.
// Saves and restores each channel's x/y history around every core step.
module iir_channel_scheduler #(
    parameter int N_CHANNELS       = 4,
    parameter int NB_DATA_IN       = 8,
    parameter int NB_DATA_OUT      = 12,
    parameter int N_INPUT_SAMPLES  = 3,
    parameter int N_OUTPUT_SAMPLES = 2
) (
    input  logic                                     i_clock,
    input  logic                                     i_reset_n,
    input  logic [N_CHANNELS-1:0]                    i_valid,
    input  logic [N_CHANNELS*NB_DATA_IN-1:0]         i_data,
    output logic [N_CHANNELS-1:0]                    o_ready,
    input  logic [N_CHANNELS-1:0]                    i_clear,
    output logic [NB_DATA_IN-1:0]                    o_core_x,
    output logic [N_INPUT_SAMPLES*NB_DATA_IN-1:0]    o_core_xh,
    output logic [N_OUTPUT_SAMPLES*NB_DATA_OUT-1:0]  o_core_yh,
    input  logic [NB_DATA_OUT-1:0]                   i_core_y,
    input  logic [N_OUTPUT_SAMPLES*NB_DATA_OUT-1:0]  i_core_yh,
    output logic                                     o_valid,
    output logic [$clog2(N_CHANNELS)-1:0]            o_channel,
    output logic [NB_DATA_OUT-1:0]                   o_data
);

    localparam int CW = $clog2(N_CHANNELS);
    localparam int XW = N_INPUT_SAMPLES * NB_DATA_IN;
    localparam int YW = N_OUTPUT_SAMPLES * NB_DATA_OUT;

    localparam logic [0:0] ARB  = 1'b0;
    localparam logic [0:0] EXEC = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] ptr;
    logic [CW-1:0] sel;
    logic [CW-1:0] sel_next;
    logic [CW-1:0] grant;
    logic          found;
    int            idx;

    logic [N_CHANNELS-1:0][XW-1:0] ctx_xh;
    logic [N_CHANNELS-1:0][YW-1:0] ctx_yh;

    // Search starts at the pointer and wraps, so every channel gets a turn.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N_CHANNELS; k++) begin
            idx = (int'(ptr) + k) % N_CHANNELS;
            if (!found && i_valid[idx]) begin
                grant = CW'(idx);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        o_ready = '0;
        if (i_reset_n && state == ARB && found) begin
            o_ready[grant] = 1'b1;
        end
    end

    assign sel_next = (sel == CW'(N_CHANNELS - 1)) ? '0 : sel + 1'b1;

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state     <= ARB;
            ptr       <= '0;
            sel       <= '0;
            ctx_xh    <= '0;
            ctx_yh    <= '0;
            o_core_x  <= '0;
            o_core_xh <= '0;
            o_core_yh <= '0;
            o_valid   <= 1'b0;
            o_channel <= '0;
            o_data    <= '0;
        end else begin
            o_valid <= 1'b0;
            unique case (state)
                ARB: begin
                    if (found) begin
                        o_core_x  <= i_data[int'(grant)*NB_DATA_IN +: NB_DATA_IN];
                        o_core_xh <= ctx_xh[grant];
                        o_core_yh <= ctx_yh[grant];
                        sel       <= grant;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    ctx_xh[sel] <= {ctx_xh[sel][XW-NB_DATA_IN-1:0], o_core_x};
                    ctx_yh[sel] <= i_core_yh;
                    o_data      <= i_core_y;
                    o_channel   <= sel;
                    o_valid     <= 1'b1;
                    ptr         <= sel_next;
                    state       <= ARB;
                end
                default: state <= ARB;
            endcase
            // A clear overrides a same-edge writeback to that channel.
            for (int c = 0; c < N_CHANNELS; c++) begin
                if (i_clear[c]) begin
                    ctx_xh[c] <= '0;
                    ctx_yh[c] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_iir_channel_scheduler.sv
// Self-checking bench: stand-in core y = x + (yh[0]>>>1) plus a
// per-channel history model checked against the DUT every cycle.
module tb_iir_channel_scheduler;

    localparam int NCH = 4;
    localparam int NBI = 8;
    localparam int NBO = 12;
    localparam int NI  = 3;
    localparam int NO  = 2;
    localparam int XW  = NI * NBI;
    localparam int YW  = NO * NBO;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    i_valid;
    logic [NCH*NBI-1:0] i_data;
    logic [NCH-1:0]    o_ready;
    logic [NCH-1:0]    i_clear;
    logic [NBI-1:0]    o_core_x;
    logic [XW-1:0]     o_core_xh;
    logic [YW-1:0]     o_core_yh;
    logic [NBO-1:0]    core_y;
    logic [YW-1:0]     core_yh;
    logic              o_valid;
    logic [1:0]        o_channel;
    logic [NBO-1:0]    o_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    iir_channel_scheduler #(
        .N_CHANNELS(NCH), .NB_DATA_IN(NBI), .NB_DATA_OUT(NBO),
        .N_INPUT_SAMPLES(NI), .N_OUTPUT_SAMPLES(NO)
    ) dut (
        .i_clock(clk), .i_reset_n(rst_n),
        .i_valid(i_valid), .i_data(i_data), .o_ready(o_ready),
        .i_clear(i_clear),
        .o_core_x(o_core_x), .o_core_xh(o_core_xh), .o_core_yh(o_core_yh),
        .i_core_y(core_y), .i_core_yh(core_yh),
        .o_valid(o_valid), .o_channel(o_channel), .o_data(o_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in filter core, purely combinational.
    always_comb begin
        core_y  = {{(NBO-NBI){o_core_x[NBI-1]}}, o_core_x}
                + NBO'($signed(o_core_yh[NBO-1:0]) >>> 1);
        core_yh = {o_core_yh[YW-NBO-1:0], core_y};
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [NBI-1:0]        m_xh [NCH][NI];
    logic signed [NBO-1:0] m_yh [NCH][NO];
    bit             started = 0;
    bit             m_busy  = 0;
    int             m_ptr   = 0;
    int             m_pc    = 0;
    logic [NBI-1:0] m_px;
    logic [NBO-1:0] m_py;
    logic [XW-1:0]  m_pxh;
    logic [YW-1:0]  m_pyh;
    bit             e_valid = 0;
    int             e_ch    = 0;
    logic [NBO-1:0] e_data;
    int             g;
    logic [NCH-1:0] er;

    function automatic logic [XW-1:0] pack_x(input int c);
        logic [XW-1:0] p;
        for (int i = 0; i < NI; i++) p[i*NBI +: NBI] = m_xh[c][i];
        return p;
    endfunction

    function automatic logic [YW-1:0] pack_y(input int c);
        logic [YW-1:0] p;
        for (int i = 0; i < NO; i++) p[i*NBO +: NBO] = m_yh[c][i];
        return p;
    endfunction

    always @(negedge clk) begin : compare
        g  = -1;
        er = '0;
        if (rst_n && !m_busy) begin
            for (int k = 0; k < NCH; k++) begin
                if (g < 0 && i_valid[(m_ptr + k) % NCH]) g = (m_ptr + k) % NCH;
            end
        end
        if (g >= 0) er[g] = 1'b1;
        if (started) begin
            chk("o_ready", int'(o_ready), int'(er));
            chk("o_valid", int'(o_valid), int'(e_valid));
            if (e_valid) begin
                chk("o_channel", int'(o_channel), e_ch);
                chk("o_data", int'(o_data), int'(e_data));
            end
            if (m_busy) begin
                chk("o_core_x", int'(o_core_x), int'(m_px));
                chk("o_core_xh", int'(o_core_xh), int'(m_pxh));
                chk("o_core_yh", int'(o_core_yh), int'(m_pyh));
            end
        end
        if (!rst_n) begin
            started = 1;
            m_busy  = 0;
            m_ptr   = 0;
            e_valid = 0;
            e_data  = '0;
            for (int c = 0; c < NCH; c++) begin
                for (int i = 0; i < NI; i++) m_xh[c][i] = '0;
                for (int i = 0; i < NO; i++) m_yh[c][i] = '0;
            end
        end else begin
            if (m_busy) begin
                for (int i = NI - 1; i > 0; i--) m_xh[m_pc][i] = m_xh[m_pc][i-1];
                m_xh[m_pc][0] = m_px;
                for (int i = NO - 1; i > 0; i--) m_yh[m_pc][i] = m_yh[m_pc][i-1];
                m_yh[m_pc][0] = m_py;
                e_valid = 1;
                e_ch    = m_pc;
                e_data  = m_py;
                m_ptr   = (m_pc + 1) % NCH;
                m_busy  = 0;
            end else begin
                e_valid = 0;
                if (g >= 0) begin
                    m_px   = i_data[g*NBI +: NBI];
                    m_pxh  = pack_x(g);
                    m_pyh  = pack_y(g);
                    m_py   = NBO'(int'($signed(m_px)) + (int'(m_yh[g][0]) >>> 1));
                    m_pc   = g;
                    m_busy = 1;
                end
            end
            for (int c = 0; c < NCH; c++) begin
                if (i_clear[c]) begin
                    for (int i = 0; i < NI; i++) m_xh[c][i] = '0;
                    for (int i = 0; i < NO; i++) m_yh[c][i] = '0;
                end
            end
        end
    end

    // ---------------- output capture ----------------
    int ov_ch[$];
    int ov_d[$];
    int ov_cyc[$];

    always @(negedge clk) begin
        if (o_valid && rst_n) begin
            ov_ch.push_back(int'(o_channel));
            ov_d.push_back(int'($signed(o_data)));
            ov_cyc.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    int sq[NCH][$];

    function automatic bit any_pending();
        bit p = 0;
        for (int c = 0; c < NCH; c++) if (sq[c].size() > 0) p = 1;
        return p;
    endfunction

    task automatic drive_from_q();
        for (int c = 0; c < NCH; c++) begin
            i_valid[c] = sq[c].size() > 0;
            i_data[c*NBI +: NBI] = (sq[c].size() > 0) ? NBI'(sq[c][0]) : '0;
        end
    endtask

    task automatic run_streams(input int budget);
        int acc;
        int n = 0;
        drive_from_q();
        while (any_pending() && n < budget) begin
            @(negedge clk);
            acc = -1;
            for (int c = 0; c < NCH; c++) if (o_ready[c]) acc = c;
            @(posedge clk);
            #1;
            if (acc >= 0) void'(sq[acc].pop_front());
            drive_from_q();
            n++;
        end
        if (any_pending()) begin
            errors++;
            $display("FAIL stream_timeout got pending want none");
            for (int c = 0; c < NCH; c++) sq[c].delete();
        end
        i_valid = '0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(posedge clk);
        #1;
        rst_n = 1'b1;
        ov_ch.delete();
        ov_d.delete();
        ov_cyc.delete();
    endtask

    task automatic expect_outs(input string nm, input int ch[], input int d[]);
        chk({nm, "_count"}, ov_d.size(), d.size());
        for (int i = 0; i < d.size(); i++) begin
            if (i < ov_d.size()) begin
                chk({nm, "_ch"}, ov_ch[i], ch[i]);
                chk({nm, "_data"}, ov_d[i], d[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        i_valid = '1;
        i_data  = '0;
        i_clear = '0;

        // 1: reset holds everything idle, even with requests pending
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("t1_valid", int'(o_valid), 0);
        chk("t1_ready", int'(o_ready), 0);
        chk("t1_data", int'(o_data), 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        i_valid = '0;
        repeat (5) @(posedge clk);
        #1;
        chk("t1_idle", ov_d.size(), 0);

        // 2: impulse on ch0
        sq[0] = '{16, 0, 0, 0};
        run_streams(40);
        expect_outs("t2", '{0, 0, 0, 0}, '{16, 8, 4, 2});
        for (int i = 1; i < 4; i++) begin
            if (i < ov_cyc.size()) chk("t2_gap", ov_cyc[i] - ov_cyc[i-1], 2);
        end

        // 3: all channels requesting continuously
        do_reset(2);
        for (int c = 0; c < NCH; c++) sq[c] = '{c + 1, c + 1};
        run_streams(60);
        expect_outs("t3", '{0, 1, 2, 3, 0, 1, 2, 3},
                    '{1, 2, 3, 4, 1, 3, 4, 6});

        // 4: interleaved impulses keep separate contexts
        do_reset(2);
        sq[1] = '{16, 0, 0};
        sq[2] = '{40, 0, 0};
        run_streams(60);
        expect_outs("t4", '{1, 2, 1, 2, 1, 2}, '{16, 40, 8, 20, 4, 10});

        // 5: clear during EXEC of ch1
        do_reset(2);
        i_valid[1] = 1'b1;
        i_data[1*NBI +: NBI] = 8'd16;
        @(negedge clk);
        chk("t5_ready", int'(o_ready), 2);
        @(posedge clk);
        #1;
        i_valid = '0;
        i_clear = 4'b0010;
        @(posedge clk);
        #1;
        i_clear = '0;
        sq[1] = '{0};
        run_streams(20);
        expect_outs("t5", '{1, 1}, '{16, 0});

        // 6: reset lands during EXEC
        do_reset(2);
        i_valid[3] = 1'b1;
        i_data[3*NBI +: NBI] = 8'd7;
        @(negedge clk);
        chk("t6_ready", int'(o_ready), 8);
        @(posedge clk);
        #1;
        i_valid = '0;
        rst_n   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_valid", ov_d.size(), 0);
        sq[3] = '{5};
        run_streams(20);
        expect_outs("t6", '{3}, '{5});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
